// File: rtl/debug_run_ctrl.sv
// debug_run_ctrl: UART-driven program loader and run/step/break sequencer for the DLX pipeline.
// After every run or step it reports the PC and the number of enabled cycles back over UART.
module debug_run_ctrl #(
  parameter int unsigned PC_W    = 6,
  parameter int unsigned CYC_W   = 32,
  parameter int unsigned IMEM_AW = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  input  logic               tx_ready,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  input  logic               halt_detect,
  input  logic [PC_W-1:0]    pc_current,
  output logic               pipe_enable,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               busy
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLdCnt  = 3'd1;
  localparam logic [2:0] StLdData = 3'd2;
  localparam logic [2:0] StAck    = 3'd3;
  localparam logic [2:0] StRun    = 3'd4;
  localparam logic [2:0] StStep   = 3'd5;
  localparam logic [2:0] StReport = 3'd6;

  localparam logic [7:0] CmdLoad  = 8'h4C;
  localparam logic [7:0] CmdRun   = 8'h52;
  localparam logic [7:0] CmdStep  = 8'h53;
  localparam logic [7:0] CmdBreak = 8'h42;
  localparam logic [7:0] AckByte  = 8'h4B;

  localparam logic [CYC_W-1:0]   CycOne  = CYC_W'(1);
  localparam logic [IMEM_AW-1:0] AddrOne = IMEM_AW'(1);

  logic [2:0]         state_q, state_d;
  logic               halted_q, halted_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d, cyc_inc;
  logic               en_q, en_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [7:0]         words_q, words_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               we_q, we_d;
  logic [PC_W-1:0]    pc_snap_q, pc_snap_d;
  logic [CYC_W-1:0]   cyc_snap_q, cyc_snap_d;
  logic               enter_report;
  logic [31:0]        cyc32;

  // Counter saturates instead of wrapping so long runs never report a small count.
  assign cyc_inc = (en_q && (cyc_q != '1)) ? cyc_q + CycOne : cyc_q;

  always_comb begin
    state_d      = state_q;
    halted_d     = halted_q;
    cyc_d        = cyc_inc;
    cnt_d        = cnt_q;
    words_d      = words_q;
    addr_d       = we_q ? addr_q + AddrOne : addr_q;
    wdata_d      = wdata_q;
    we_d         = 1'b0;
    pc_snap_d    = pc_snap_q;
    cyc_snap_d   = cyc_snap_q;
    enter_report = 1'b0;

    case (state_q)
      StIdle: begin
        if (rx_valid) begin
          case (rx_data)
            CmdLoad: begin
              state_d  = StLdCnt;
              halted_d = 1'b0;
              cyc_d    = '0;
              addr_d   = '0;
            end
            CmdRun: begin
              if (halted_q) enter_report = 1'b1;
              else          state_d      = StRun;
            end
            CmdStep: begin
              if (halted_q) enter_report = 1'b1;
              else          state_d      = StStep;
            end
            default: ;
          endcase
        end
      end
      StLdCnt: begin
        if (rx_valid) begin
          cnt_d   = 3'd0;
          words_d = rx_data;
          state_d = (rx_data == 8'd0) ? StAck : StLdData;
        end
      end
      StLdData: begin
        if (rx_valid) begin
          wdata_d = {wdata_q[23:0], rx_data};
          if (cnt_q == 3'd3) begin
            cnt_d   = 3'd0;
            we_d    = 1'b1;
            words_d = words_q - 8'd1;
            if (words_q == 8'd1) state_d = StAck;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      StAck: begin
        if (tx_ready) state_d = StIdle;
      end
      StRun: begin
        // Halt takes priority over a simultaneous break so the halted flag is never lost.
        if (halt_detect) begin
          halted_d     = 1'b1;
          enter_report = 1'b1;
        end else if (rx_valid && (rx_data == CmdBreak)) begin
          enter_report = 1'b1;
        end
      end
      StStep: begin
        if (halt_detect) halted_d = 1'b1;
        enter_report = 1'b1;
      end
      StReport: begin
        if (tx_ready) begin
          if (cnt_q == 3'd4) begin
            cnt_d   = 3'd0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Snapshot includes the final enabled cycle that is being counted on this same edge.
    if (enter_report) begin
      state_d    = StReport;
      cnt_d      = 3'd0;
      pc_snap_d  = pc_current;
      cyc_snap_d = cyc_d;
    end
  end

  assign en_d = (state_d == StRun) || (state_d == StStep);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      halted_q   <= 1'b0;
      cyc_q      <= '0;
      en_q       <= 1'b0;
      cnt_q      <= 3'd0;
      words_q    <= 8'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      we_q       <= 1'b0;
      pc_snap_q  <= '0;
      cyc_snap_q <= '0;
    end else begin
      state_q    <= state_d;
      halted_q   <= halted_d;
      cyc_q      <= cyc_d;
      en_q       <= en_d;
      cnt_q      <= cnt_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      pc_snap_q  <= pc_snap_d;
      cyc_snap_q <= cyc_snap_d;
    end
  end

  assign cyc32 = 32'(cyc_snap_q);

  always_comb begin
    tx_data = 8'd0;
    if (state_q == StAck) begin
      tx_data = AckByte;
    end else if (state_q == StReport) begin
      case (cnt_q)
        3'd0:    tx_data = 8'(pc_snap_q);
        3'd1:    tx_data = cyc32[31:24];
        3'd2:    tx_data = cyc32[23:16];
        3'd3:    tx_data = cyc32[15:8];
        default: tx_data = cyc32[7:0];
      endcase
    end
  end

  assign tx_valid    = (state_q == StAck) || (state_q == StReport);
  assign pipe_enable = en_q;
  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Randomized bench for debug_run_ctrl: commands are driven over the rx strobe and the observed
// writes, enable cycles and tx bytes are compared with a transaction-level model.
module tb_debug_run_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        tx_ready = 1'b0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        halt_detect = 1'b0;
  logic [5:0]  pc_current = 6'd0;
  logic        pipe_enable;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;

  debug_run_ctrl #(
    .PC_W   (6),
    .CYC_W  (32),
    .IMEM_AW(10)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_ready   (tx_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .halt_detect(halt_detect),
    .pc_current (pc_current),
    .pipe_enable(pipe_enable),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: what the controller should remember between commands.
  logic        m_halted = 1'b0;
  logic [31:0] m_cyc    = 32'd0;

  // Observations collected by the monitor.
  logic [7:0]  tx_q[$];
  logic [9:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          en_cnt = 0;
  logic        hold_ready = 1'b0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'd0;
  logic [31:0] load_words [0:7];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  always begin
    @(posedge clock);
    #2;
    tx_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  always @(negedge clock) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (pipe_enable) en_cnt++;
      if (imem_we) begin
        wr_addr_q.push_back(imem_addr);
        wr_data_q.push_back(imem_wdata);
        chk("we_with_enable", 32'(pipe_enable), 32'd0);
      end
      if (prev_stall) begin
        chk("tx_hold_valid", 32'(tx_valid), 32'd1);
        chk("tx_hold_data", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic clear_obs();
    tx_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    en_cnt = 0;
  endtask

  function automatic logic [31:0] sat_add(input logic [31:0] a, input int k);
    longint s;
    s = longint'(a) + longint'(k);
    return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
  endfunction

  task automatic wait_tx(input int n, input logic scramble);
    int t = 0;
    logic done_scr = 1'b0;
    while (tx_q.size() < n && t < 600) begin
      // Once the report is on the wire the PC may move; the snapshot must not follow it.
      if (scramble && tx_valid && !done_scr) begin
        pc_current = 6'($urandom);
        done_scr   = 1'b1;
      end
      tick();
      t++;
    end
    if (tx_q.size() < n) chk("tx_timeout", 32'(tx_q.size()), 32'(n));
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 100) begin
      tick();
      t++;
    end
    chk("back_to_idle", 32'(busy), 32'd0);
  endtask

  task automatic check_report(input logic [5:0] pc, input logic [31:0] cyc, input int en_exp);
    logic [7:0] exp_b [0:4];
    exp_b[0] = {2'b00, pc};
    exp_b[1] = cyc[31:24];
    exp_b[2] = cyc[23:16];
    exp_b[3] = cyc[15:8];
    exp_b[4] = cyc[7:0];
    wait_tx(5, 1'b1);
    for (int i = 0; i < 5 && i < tx_q.size(); i++)
      chk($sformatf("rpt_byte%0d", i), 32'(tx_q[i]), 32'(exp_b[i]));
    wait_idle();
    chk("rpt_len", 32'(tx_q.size()), 32'd5);
    chk("en_cycles", 32'(en_cnt), 32'(en_exp));
  endtask

  task automatic do_load(input int n);
    clear_obs();
    send_byte(8'h4C);
    gap();
    send_byte(8'(n));
    for (int w = 0; w < n; w++) begin
      for (int b = 3; b >= 0; b--) begin
        gap();
        send_byte(load_words[w][8*b +: 8]);
      end
    end
    m_halted = 1'b0;
    m_cyc    = 32'd0;
    wait_tx(1, 1'b0);
    if (tx_q.size() > 0) chk("ack_byte", 32'(tx_q[0]), 32'h4B);
    wait_idle();
    chk("ack_len", 32'(tx_q.size()), 32'd1);
    chk("ld_nwrites", 32'(wr_addr_q.size()), 32'(n));
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      chk($sformatf("ld_addr%0d", i), 32'(wr_addr_q[i]), 32'(i));
      chk($sformatf("ld_data%0d", i), wr_data_q[i], load_words[i]);
    end
    chk("ld_en", 32'(en_cnt), 32'd0);
  endtask

  task automatic do_step(input logic h, input logic hold);
    logic [5:0]  pc;
    logic [31:0] exp_cyc;
    int          exp_en;
    clear_obs();
    pc = pc_current;
    if (m_halted) begin
      exp_en  = 0;
      exp_cyc = m_cyc;
    end else begin
      exp_en   = 1;
      exp_cyc  = sat_add(m_cyc, 1);
      m_halted = h;
    end
    m_cyc = exp_cyc;
    halt_detect = h;
    send_byte(8'h53);
    tick();
    halt_detect = 1'b0;
    if (hold) begin
      for (int t = 0; t < 20 && !tx_valid; t++) tick();
      hold_ready = 1'b1;
      pc_current = 6'($urandom);
      repeat (20) tick();
      chk("hold_no_xfer", 32'(tx_q.size()), 32'd0);
      hold_ready = 1'b0;
    end
    check_report(pc, exp_cyc, exp_en);
  endtask

  // mode 0: halt, 1: break, 2: halt and break together.
  task automatic do_run(input int k, input int mode);
    logic [5:0]  pc;
    logic [31:0] exp_cyc;
    int          exp_en;
    int          cnt = 0;
    logic        done = 1'b0;
    logic [7:0]  junk;
    clear_obs();
    pc = pc_current;
    exp_en  = m_halted ? 0 : k;
    exp_cyc = sat_add(m_cyc, exp_en);
    send_byte(8'h52);
    if (!m_halted) begin
      for (int t = 0; t < 200 && !done; t++) begin
        rx_valid = 1'b0;
        if (pipe_enable) begin
          cnt++;
          if (cnt == k) begin
            halt_detect = (mode != 1);
            if (mode != 0) begin
              rx_valid = 1'b1;
              rx_data  = 8'h42;
            end
            done = 1'b1;
          end else if ($urandom_range(0, 3) == 0) begin
            do junk = 8'($urandom); while (junk == 8'h42);
            rx_valid = 1'b1;
            rx_data  = junk;
          end
        end
        tick();
      end
      rx_valid    = 1'b0;
      halt_detect = 1'b0;
      if (!done) chk("run_stim_timeout", 32'(cnt), 32'(k));
      m_halted = (mode != 1);
    end
    m_cyc = exp_cyc;
    check_report(pc, exp_cyc, exp_en);
  endtask

  task automatic do_junk(input logic [7:0] b);
    clear_obs();
    send_byte(b);
    repeat (4) tick();
    chk("junk_busy", 32'(busy), 32'd0);
    chk("junk_tx", 32'(tx_q.size()), 32'd0);
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_tx_valid"}, 32'(tx_valid), 32'd0);
    chk({pfx, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({pfx, "_enable"}, 32'(pipe_enable), 32'd0);
    chk({pfx, "_we"}, 32'(imem_we), 32'd0);
    chk({pfx, "_addr"}, 32'(imem_addr), 32'd0);
    chk({pfx, "_wdata"}, imem_wdata, 32'd0);
    chk({pfx, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] jb;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    tick();
    chk_outputs_zero("reset");

    pc_current = 6'd5;
    do_step(1'b0, 1'b0);

    load_words[0] = 32'hDEADBEEF;
    load_words[1] = 32'h00000001;
    do_load(2);

    do_run(10, 0);
    do_run(5, 0);

    do_load(0);
    do_run(3, 2);
    do_junk(8'h41);

    // Abort a load after the second data byte with an asynchronous reset.
    load_words[0] = 32'h12345678;
    send_byte(8'h4C);
    send_byte(8'h02);
    send_byte(8'hDE);
    send_byte(8'hAD);
    #2;
    reset = 1'b0;
    #1;
    chk_outputs_zero("async_rst");
    m_halted = 1'b0;
    m_cyc    = 32'd0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    do_load(1);

    pc_current = 6'd33;
    do_step(1'b0, 1'b1);

    for (int op = 0; op < 30; op++) begin
      pc_current = 6'($urandom);
      gap();
      case ($urandom_range(0, 4))
        0: begin
          for (int i = 0; i < 8; i++) load_words[i] = $urandom;
          do_load($urandom_range(0, 4));
        end
        1: do_step(1'($urandom_range(0, 1)), 1'b0);
        2: do_run($urandom_range(1, 20), $urandom_range(0, 2));
        3: begin
          do jb = 8'($urandom); while (jb == 8'h4C || jb == 8'h52 || jb == 8'h53);
          do_junk(jb);
        end
        default: do_run($urandom_range(1, 6), 1);
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
